// File: rtl/axis_upsize_buffer.sv
// Packs narrow AXI-Stream beats into wide words (first beat most significant) and buffers
// them in a synchronous-read RAM drained through a registered output stage.
module axis_upsize_buffer #(
   parameter int unsigned W_IN  = 16,
   parameter int unsigned W_OUT = 96,
   parameter int unsigned DEPTH = 4
) (
   input  logic                                 clk,
   input  logic                                 rstn,
   input  logic                                 clken,
   input  logic                                 s_valid,
   output logic                                 s_ready,
   input  logic [W_IN-1:0]                      s_data,
   input  logic                                 s_last,
   output logic                                 m_valid,
   input  logic                                 m_ready,
   output logic [W_OUT-1:0]                     m_data,
   output logic                                 m_last,
   output logic [$clog2(W_OUT/W_IN+1)-1:0]      m_count
);

   localparam int unsigned K  = W_OUT / W_IN;
   localparam int unsigned CW = $clog2(K + 1);
   localparam int unsigned LW = $clog2(K);
   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned NW = $clog2(DEPTH + 1);
   localparam int unsigned EW = W_OUT + 1 + CW;

   typedef enum logic [1:0] {StEmpty, StFetch, StValid} state_e;

   state_e          state_q, state_d;
   logic [LW-1:0]   lane_q;
   logic [W_OUT-1:0] pack_q, pack_ins;
   logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [NW-1:0]   count_q;
   logic            s_fire, close, rd_en, load;
   logic [EW-1:0]   wr_word, ram_q;
   logic [EW-1:0]   mem [DEPTH];

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   // Ready depends only on registered occupancy, never on the output side.
   assign s_ready = clken && (count_q != NW'(DEPTH));
   assign s_fire  = s_valid && s_ready;
   assign close   = s_fire && (s_last || (lane_q == LW'(K - 1)));

   always_comb begin
      pack_ins = pack_q;
      for (int j = 0; j < K; j++) begin
         if (lane_q == LW'(j)) pack_ins[W_OUT-1-j*W_IN -: W_IN] = s_data;
      end
   end

   assign wr_word = {pack_ins, s_last, CW'(lane_q) + CW'(1)};

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         lane_q <= '0;
         pack_q <= '0;
      end else if (s_fire) begin
         if (close) begin
            lane_q <= '0;
            pack_q <= '0;
         end else begin
            lane_q <= lane_q + LW'(1);
            pack_q <= pack_ins;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (close) wr_ptr_q <= ptr_inc(wr_ptr_q);
         if (rd_en) rd_ptr_q <= ptr_inc(rd_ptr_q);
         count_q <= count_q + NW'(close) - NW'(rd_en);
      end
   end

   // Storage RAM: no reset so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (clken) begin
         if (close) mem[wr_ptr_q] <= wr_word;
         if (rd_en) ram_q <= mem[rd_ptr_q];
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state_q <= StEmpty;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StEmpty: if (clken && (count_q != '0)) state_d = StFetch;
         StFetch: if (clken) state_d = StValid;
         StValid: begin
            if (clken && m_ready) state_d = (count_q != '0) ? StFetch : StEmpty;
         end
         default: state_d = StEmpty;
      endcase
   end

   always_comb begin
      rd_en   = clken && (count_q != '0) &&
                ((state_q == StEmpty) || ((state_q == StValid) && m_ready));
      load    = clken && (state_q == StFetch);
      m_valid = (state_q == StValid);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         m_data  <= '0;
         m_last  <= 1'b0;
         m_count <= '0;
      end else if (load) begin
         {m_data, m_last, m_count} <= ram_q;
      end
   end

endmodule

// File: tb/tb_axis_upsize_buffer.sv
// Scoreboard bench for axis_upsize_buffer: packets are split into expected wide words
// when issued; a negedge monitor pops and compares every output handshake.
module tb_axis_upsize_buffer;

   localparam int W_IN  = 16;
   localparam int W_OUT = 96;
   localparam int DEPTH = 4;
   localparam int K     = W_OUT / W_IN;
   localparam int CW    = $clog2(K + 1);

   logic             clk = 1'b0;
   logic             rstn, clken;
   logic             s_valid, s_ready, s_last;
   logic [W_IN-1:0]  s_data;
   logic             m_valid, m_ready, m_last;
   logic [W_OUT-1:0] m_data;
   logic [CW-1:0]    m_count;

   typedef struct {
      logic [W_OUT-1:0] data;
      logic             last;
      logic [CW-1:0]    cnt;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_vec = 0, n_err = 0, acc_cnt = 0, word_cnt = 0;
   bit   rnd_mready = 1'b0, mready_fix = 1'b0;

   logic [W_OUT-1:0] hold_d;
   logic             hold_l;
   logic [CW-1:0]    hold_c;
   bit               hold_v = 1'b0;

   always #5 clk = ~clk;

   axis_upsize_buffer #(.W_IN(W_IN), .W_OUT(W_OUT), .DEPTH(DEPTH)) dut (
      .clk(clk), .rstn(rstn), .clken(clken),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
      .m_count(m_count)
   );

   task automatic check(input string name, input logic [W_OUT-1:0] got,
                        input logic [W_OUT-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic push_word(input logic [W_OUT-1:0] d, input int cnt, input logic last);
      exp_t e;
      e.data = d;
      e.cnt  = CW'(cnt);
      e.last = last;
      exp_q.push_back(e);
   endtask

   // Reference: a packet splits into chunks of K beats, the final chunk carries last.
   task automatic model_packet(input logic [W_IN-1:0] beats[$]);
      int n, i, take;
      logic [W_OUT-1:0] d, lanev;
      n = beats.size();
      i = 0;
      while (i < n) begin
         take = (n - i < K) ? n - i : K;
         d = '0;
         for (int j = 0; j < take; j++) begin
            lanev = W_OUT'(beats[i+j]);
            d |= lanev << (W_OUT - (j + 1) * W_IN);
         end
         push_word(d, take, (i + take == n));
         i += take;
      end
   endtask

   task automatic send_beat(input logic [W_IN-1:0] d, input logic l, input bit rnd);
      bit acc;
      int n;
      if (rnd) begin
         while ($urandom_range(1, 0) == 0) begin
            s_valid = 1'b0;
            @(posedge clk); #1;
         end
      end
      s_valid = 1'b1;
      s_data  = d;
      s_last  = l;
      acc = 1'b0;
      n = 0;
      while (!acc) begin
         @(negedge clk);
         acc = s_ready;
         @(posedge clk); #1;
         n++;
         if (!acc && n > 2000) begin
            n_vec++;
            n_err++;
            $display("FAIL s_handshake_timeout: beat %0h not accepted in %0d cycles", d, n);
            break;
         end
      end
   endtask

   task automatic send_packet(input logic [W_IN-1:0] beats[$], input bit rnd, input bit model);
      if (model) model_packet(beats);
      foreach (beats[i]) send_beat(beats[i], (i == beats.size() - 1), rnd);
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic wait_drain(input int budget);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(posedge clk);
         n++;
      end
      #1;
      check("drain_pending_words", W_OUT'(exp_q.size()), '0);
   endtask

   always begin
      @(posedge clk); #2;
      m_ready = rnd_mready ? 1'($urandom_range(1, 0)) : mready_fix;
   end

   // Monitor: handshakes complete at the following rising edge.
   always @(negedge clk) begin
      if (!rstn) begin
         hold_v = 1'b0;
      end else begin
         if (hold_v) begin
            check("hold_valid", W_OUT'(m_valid), W_OUT'(1));
            check("hold_data", m_data, hold_d);
            check("hold_last", W_OUT'(m_last), W_OUT'(hold_l));
            check("hold_count", W_OUT'(m_count), W_OUT'(hold_c));
         end
         hold_v = m_valid && !(m_ready && clken);
         hold_d = m_data;
         hold_l = m_last;
         hold_c = m_count;
         if (m_valid && m_ready && clken) begin
            word_cnt++;
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_word: got %0h with none expected", m_data);
            end else begin
               mon_e = exp_q.pop_front();
               check("word_data", m_data, mon_e.data);
               check("word_last", W_OUT'(m_last), W_OUT'(mon_e.last));
               check("word_count", W_OUT'(m_count), W_OUT'(mon_e.cnt));
            end
         end
         if (s_valid && s_ready) acc_cnt++;
      end
   end

   initial begin
      #500000;
      n_err++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W_IN-1:0] bq[$];
      int base, words, rem, maxlen, len, n, qsz;

      rstn = 1'b0; clken = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
      m_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_m_valid", W_OUT'(m_valid), '0);
      check("reset_m_data", m_data, '0);
      check("reset_m_last", W_OUT'(m_last), '0);
      check("reset_m_count", W_OUT'(m_count), '0);
      @(posedge clk); #1;
      rstn = 1'b1;
      @(negedge clk);
      check("release_s_ready", W_OUT'(s_ready), W_OUT'(1));

      // Two full words from a 12-beat packet.
      mready_fix = 1'b1;
      @(posedge clk); #1;
      push_word(96'h0001_0002_0003_0004_0005_0006, 6, 1'b0);
      push_word(96'h0007_0008_0009_000A_000B_000C, 6, 1'b1);
      bq = {};
      for (int i = 1; i <= 12; i++) bq.push_back(W_IN'(i));
      send_packet(bq, 1'b0, 1'b0);
      wait_drain(100);

      // Short packet closed early: zero-filled lanes.
      push_word(96'hAAAA_BBBB_CCCC_0000_0000_0000, 3, 1'b1);
      bq = {16'hAAAA, 16'hBBBB, 16'hCCCC};
      send_packet(bq, 1'b0, 1'b0);
      wait_drain(100);

      // Backpressure: capacity is DEPTH words plus the output register.
      mready_fix = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      base = acc_cnt;
      bq = {};
      for (int i = 0; i < 36; i++) bq.push_back(W_IN'(16'h3000 + i));
      fork
         send_packet(bq, 1'b0, 1'b1);
         begin
            repeat (50) @(posedge clk);
            @(negedge clk); #1;
            check("stall_accepted_beats", W_OUT'(acc_cnt - base), W_OUT'(30));
            check("stall_s_ready", W_OUT'(s_ready), '0);
            check("stall_pending_words", W_OUT'(exp_q.size()), W_OUT'(6));
            mready_fix = 1'b1;
         end
      join
      wait_drain(200);

      // Random traffic: 40 words, both sides throttled.
      base = word_cnt;
      words = 0;
      rnd_mready = 1'b1;
      while (words < 40) begin
         rem = 40 - words;
         maxlen = (rem * K > 18) ? 18 : rem * K;
         len = $urandom_range(maxlen, 1);
         bq = {};
         for (int i = 0; i < len; i++) bq.push_back(W_IN'($urandom));
         send_packet(bq, 1'b1, 1'b1);
         words += (len + K - 1) / K;
      end
      rnd_mready = 1'b0;
      mready_fix = 1'b1;
      wait_drain(1000);
      check("random_word_total", W_OUT'(word_cnt - base), W_OUT'(40));

      // Reset with two stored words and a partial word in flight.
      mready_fix = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 16; i++) send_beat(W_IN'(16'h4000 + i), 1'b0, 1'b0);
      s_valid = 1'b0;
      repeat (4) @(posedge clk);
      #3;
      check("pre_reset_m_valid", W_OUT'(m_valid), W_OUT'(1));
      rstn = 1'b0;
      #1;
      check("async_reset_m_valid", W_OUT'(m_valid), '0);
      check("async_reset_m_data", m_data, '0);
      check("async_reset_m_count", W_OUT'(m_count), '0);
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rstn = 1'b1;
      mready_fix = 1'b1;
      base = word_cnt;
      bq = {};
      for (int i = 0; i < 6; i++) bq.push_back(W_IN'(16'h5100 + i));
      send_packet(bq, 1'b0, 1'b1);
      wait_drain(100);
      repeat (20) @(posedge clk);
      #1;
      check("post_reset_word_total", W_OUT'(word_cnt - base), W_OUT'(1));

      // Clock enable low freezes both handshakes and all state.
      mready_fix = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      bq = {};
      for (int i = 0; i < 6; i++) bq.push_back(W_IN'(16'h6100 + i));
      send_packet(bq, 1'b0, 1'b1);
      n = 0;
      while (!m_valid && n < 30) begin
         @(negedge clk);
         n++;
      end
      check("clken_setup_valid", W_OUT'(m_valid), W_OUT'(1));
      @(posedge clk); #1;
      clken = 1'b0;
      mready_fix = 1'b1;
      s_valid = 1'b1;
      s_data = 16'h7777;
      s_last = 1'b1;
      push_word(96'h7777_0000_0000_0000_0000_0000, 1, 1'b1);
      base = acc_cnt;
      qsz = exp_q.size();
      repeat (3) begin
         @(negedge clk); #1;
         check("clken_s_ready", W_OUT'(s_ready), '0);
         check("clken_m_valid", W_OUT'(m_valid), W_OUT'(1));
         check("clken_m_data", m_data, exp_q[0].data);
         check("clken_no_accept", W_OUT'(acc_cnt - base), '0);
         check("clken_no_pop", W_OUT'(exp_q.size()), W_OUT'(qsz));
      end
      @(posedge clk); #1;
      clken = 1'b1;
      n = 0;
      while (acc_cnt == base && n < 10) begin
         @(negedge clk); #1;
         n++;
      end
      @(posedge clk); #1;
      s_valid = 1'b0;
      s_last = 1'b0;
      check("clken_resume_accept", W_OUT'(acc_cnt - base), W_OUT'(1));
      wait_drain(100);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/axis_upsize_buffer.md
AXIS_UPSIZE_BUFFER -- requirements
Module: axis_upsize_buffer

Interface
REQ-001 SHALL have parameter W_IN, default 16: narrow input beat width in bits (multiple of 8).
REQ-002 SHALL have parameter W_OUT, default 96: wide output word width in bits; K = W_OUT/W_IN, which is an integer of 2 or more.
REQ-003 SHALL have parameter DEPTH, default 4: number of wide-word storage entries (power of 2).
REQ-004 SHALL have port clk  in  1: single clock; all state updates on the rising edge.
REQ-005 SHALL have port rstn  in  1: reset, asynchronous and active-low.
REQ-006 SHALL have port clken  in  1: global clock enable; when 0, all state holds.
REQ-007 SHALL have port s_valid  in  1: input beat valid.
REQ-008 SHALL have port s_ready  out  1: input beat accepted when s_valid && s_ready.
REQ-009 SHALL have port s_data  in  W_IN: input beat.
REQ-010 SHALL have port s_last  in  1: last beat of packet.
REQ-011 SHALL have port m_valid  out  1: output word valid.
REQ-012 SHALL have port m_ready  in  1: output word consumed when m_valid && m_ready && clken.
REQ-013 SHALL have port m_data  out  W_OUT: packed wide word.
REQ-014 SHALL have port m_last  out  1: word contains the last beat of its packet.
REQ-015 SHALL have port m_count  out  $clog2(K+1): number of valid beats (1..K) in m_data.

Function
REQ-016 SHALL place accepted beat j (j = 0..K-1) of a word at m_data[W_OUT-1-j*W_IN -: W_IN], so the first beat is most significant.
REQ-017 SHALL close a word on the K-th accepted beat or on an accepted beat with s_last=1, whichever comes first.
REQ-018 SHALL zero-fill unused lanes of a word closed early by s_last, store m_count equal to the beats accepted, and store m_last=1 with that word.
REQ-019 SHALL write a closed word, its m_last flag and its m_count into storage at wr_ptr in the closing cycle, then increment wr_ptr modulo DEPTH and reset the lane index to 0.
REQ-020 SHALL keep a registered count of stored-but-unfetched words in the range 0..DEPTH, incremented on each write and decremented on each read issue; a simultaneous write and read issue leaves count unchanged.
REQ-021 SHALL drive s_ready = clken && (count != DEPTH), combinationally from registered count only.
REQ-022 SHALL implement storage as synchronous-read RAM (inferable BRAM) with 1-cycle read latency.
REQ-023 SHALL implement the output FSM with states EMPTY, FETCH and VALID.
REQ-024 SHALL, in EMPTY with count>0, issue a read at rd_ptr, increment rd_ptr modulo DEPTH, and go to FETCH.
REQ-025 SHALL, in FETCH, capture the RAM output into m_data/m_last/m_count and go to VALID.
REQ-026 SHALL, in VALID on a handshake, issue the next read and go to FETCH if count>0, else go to EMPTY.
REQ-027 SHALL hold m_data, m_last and m_count stable while m_valid && !m_ready.
REQ-028 SHALL assert m_valid exactly in VALID; sustained throughput is one word per 2 cycles.
REQ-029 SHALL make a word written in cycle t eligible for read issue in cycle t+1 at the earliest.
REQ-030 SHALL give a total capacity of DEPTH words in RAM plus 1 word in the output register, plus up to K-1 beats in the packing register.
REQ-031 SHALL, when clken=0, update no register (pointers, count, lane index, FSM, outputs) and complete no handshake.

Reset
REQ-032 SHALL, while rstn=0, asynchronously force: m_valid=0, m_data=0, m_last=0, m_count=0, FSM=EMPTY, count=0, wr_ptr=0, rd_ptr=0, lane index=0, packing register=0.
REQ-033 SHALL discard all stored data and any partial word on reset mid-operation; the first beat after release is lane 0.
REQ-034 SHALL drive s_ready=clken after reset release; RAM contents need no reset.

Verification
REQ-035 SHALL cover: 12 beats 0x0001..0x000C, last on beat 12, m_ready=1 -> word0 = 0x0001_0002_0003_0004_0005_0006, m_count=6, m_last=0; word1 = 0x0007..0x000C, m_count=6, m_last=1.
REQ-036 SHALL cover: 3 beats 0xAAAA, 0xBBBB, 0xCCCC with last on beat 3 -> m_data = 0xAAAA_BBBB_CCCC_0000_0000_0000, m_count=3, m_last=1.
REQ-037 SHALL cover: m_ready=0, continuous s_valid -> exactly 30 beats accepted, s_ready=0 from the cycle after the 30th acceptance; after m_ready=1, 5 words drain in order.
REQ-038 SHALL cover: 40 words with random s_valid/m_ready (about 50%) -> pointers wrap 10 times, output matches the scoreboard, no loss and no duplication.
REQ-039 SHALL cover: rstn pulsed low after 4 beats with 2 words stored -> m_valid=0 immediately, no old word appears afterward, and a new 6-beat word packs from lane 0.
REQ-040 SHALL cover: clken=0 for 3 cycles with s_valid=m_valid=1 -> s_ready=0, no acceptance, no pop, m_data unchanged.
